// File: rtl/plru_pkg.sv
// Tree-PLRU helper functions and sweep FSM encoding shared by plru_set_array.
// Functions work on trees up to 64 ways; callers pass their own tree depth.
package plru_pkg;

  localparam int PLRU_MAX_WAYS = 64;
  localparam int PLRU_MAX_LVL  = 6;

  typedef logic [PLRU_MAX_WAYS-1:0] tree_t;
  typedef logic [PLRU_MAX_LVL-1:0]  way_t;

  typedef enum logic {IDLE, SWEEP} sweep_state_e;

  // Heap walk: node index grows by appending the branch bit, so it doubles as the path.
  function automatic tree_t plru_update(input tree_t state, input way_t way, input int levels);
    tree_t                 s;
    way_t                  w;
    logic [PLRU_MAX_LVL:0] node;
    logic                  b;
    s    = state;
    w    = way << (PLRU_MAX_LVL - levels);
    node = {{PLRU_MAX_LVL{1'b0}}, 1'b1};
    for (int l = 0; l < PLRU_MAX_LVL; l++) begin
      if (l < levels) begin
        b                          = w[PLRU_MAX_LVL-1];
        s[node[PLRU_MAX_LVL-1:0]]  = b;
        node                       = {node[PLRU_MAX_LVL-1:0], b};
        w                          = w << 1;
      end
    end
    return s;
  endfunction

  function automatic way_t plru_victim(input tree_t state, input int levels);
    logic [PLRU_MAX_LVL:0] node;
    logic                  b;
    way_t                  mask;
    node = {{PLRU_MAX_LVL{1'b0}}, 1'b1};
    for (int l = 0; l < PLRU_MAX_LVL; l++) begin
      if (l < levels) begin
        b    = ~state[node[PLRU_MAX_LVL-1:0]];
        node = {node[PLRU_MAX_LVL-1:0], b};
      end
    end
    mask = way_t'((7'd1 << levels) - 7'd1);
    return node[PLRU_MAX_LVL-1:0] & mask;
  endfunction

  function automatic way_t lowest_set(input tree_t mask);
    way_t  r;
    logic  found;
    tree_t m;
    r     = '0;
    found = 1'b0;
    m     = mask;
    for (int i = 0; i < PLRU_MAX_WAYS; i++) begin
      if (!found && m[0]) begin
        r     = way_t'(i);
        found = 1'b1;
      end
      m = m >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/plru_set_array_if.sv
// Touch / victim-request / flush bundle between refill logic and plru_set_array.
interface plru_set_array_if #(
  parameter  int NWAYS = 8,
  parameter  int NSETS = 16,
  localparam int WAY_W = $clog2(NWAYS),
  localparam int SET_W = (NSETS > 1) ? $clog2(NSETS) : 1
);
  logic             flush;
  logic             busy;
  logic             touch_valid;
  logic [SET_W-1:0] touch_set;
  logic [WAY_W-1:0] touch_way;
  logic             vreq_valid;
  logic             vreq_ready;
  logic [SET_W-1:0] vreq_set;
  logic [NWAYS-1:0] vreq_inv_mask;
  logic             vrsp_valid;
  logic [WAY_W-1:0] vrsp_way;

  modport master (
    output flush, touch_valid, touch_set, touch_way, vreq_valid, vreq_set, vreq_inv_mask,
    input  busy, vreq_ready, vrsp_valid, vrsp_way
  );

  modport slave (
    input  flush, touch_valid, touch_set, touch_way, vreq_valid, vreq_set, vreq_inv_mask,
    output busy, vreq_ready, vrsp_valid, vrsp_way
  );
endinterface

// File: rtl/plru_tree.sv
// Combinational wrapper around one PLRU tree: touch update and victim walk.
module plru_tree
  import plru_pkg::*;
#(
  parameter  int NWAYS = 8,
  localparam int WAY_W = $clog2(NWAYS)
) (
  input  logic [NWAYS-1:0] state,
  input  logic [WAY_W-1:0] way,
  output logic [NWAYS-1:0] next_state,
  output logic [WAY_W-1:0] victim
);

  assign next_state = NWAYS'(plru_update(tree_t'(state), way_t'(way), WAY_W));
  assign victim     = WAY_W'(plru_victim(tree_t'(state), WAY_W));

endmodule

// File: rtl/plru_set_array.sv
// Per-set tree-PLRU state with forwarded victim lookup and a clearing sweep.
// Define PLRU_VICTIM_TOUCH_EN to make each granted victim the MRU way of its set.
module plru_set_array
  import plru_pkg::*;
#(
  parameter  int NWAYS = 8,
  parameter  int NSETS = 16,
  localparam int WAY_W = $clog2(NWAYS),
  localparam int SET_W = (NSETS > 1) ? $clog2(NSETS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  plru_set_array_if.slave bus
);

  logic [NWAYS-1:0] mem [NSETS];

  sweep_state_e     state_q, state_d;
  logic [SET_W-1:0] ptr_q, ptr_d;
  logic             busy;
  logic [SET_W-1:0] t_set, v_set;
  logic             touch_en, accept;
  logic [NWAYS-1:0] touch_next, fwd_state, vic_next;
  logic [WAY_W-1:0] unused_touch_victim, tree_victim, victim_way;
  logic             vrsp_vld_p1;
  logic [WAY_W-1:0] vrsp_way_p1;

  assign t_set = (NSETS == 1) ? '0 : bus.touch_set;
  assign v_set = (NSETS == 1) ? '0 : bus.vreq_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SWEEP;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        ptr_d = ptr_q + SET_W'(1);
        if (ptr_q == SET_W'(NSETS - 1)) state_d = IDLE;
      end
    endcase
  end

  assign busy           = (state_q == SWEEP);
  assign bus.busy       = busy;
  assign bus.vreq_ready = !busy;

  // A flush in the same cycle wins over a touch.
  assign touch_en = bus.touch_valid && !busy && !bus.flush;
  assign accept   = bus.vreq_valid && !busy;

  plru_tree #(.NWAYS(NWAYS)) u_touch_tree (
    .state      (mem[t_set]),
    .way        (bus.touch_way),
    .next_state (touch_next),
    .victim     (unused_touch_victim)
  );

  assign fwd_state  = (touch_en && (t_set == v_set)) ? touch_next : mem[v_set];
  assign victim_way = (|bus.vreq_inv_mask)
                    ? WAY_W'(lowest_set(tree_t'(bus.vreq_inv_mask)))
                    : tree_victim;

  plru_tree #(.NWAYS(NWAYS)) u_vic_tree (
    .state      (fwd_state),
    .way        (victim_way),
    .next_state (vic_next),
    .victim     (tree_victim)
  );

`ifndef PLRU_VICTIM_TOUCH_EN
  logic unused_vic_next;
  assign unused_vic_next = ^vic_next;
`endif

  // Array write port; the victim touch, when enabled, lands last so it already contains any same-set touch.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[ptr_q] <= '0;
    end else begin
      if (touch_en) mem[t_set] <= touch_next;
`ifdef PLRU_VICTIM_TOUCH_EN
      if (accept) mem[v_set] <= vic_next;
`endif
    end
  end

  // Stage p1: registered victim response.
  always_ff @(posedge clk) begin
    if (reset) begin
      vrsp_vld_p1 <= 1'b0;
      vrsp_way_p1 <= '0;
    end else begin
      vrsp_vld_p1 <= accept;
      if (accept) vrsp_way_p1 <= victim_way;
    end
  end

  assign bus.vrsp_valid = vrsp_vld_p1;
  assign bus.vrsp_way   = vrsp_way_p1;

endmodule

// File: tb/tb_plru_set_array.sv
// Directed bench for plru_set_array against a per-way recency model (8 ways, 16 sets).
module tb_plru_set_array;

  localparam int NWAYS = 8;
  localparam int NSETS = 16;

  logic clk;
  logic reset;

  plru_set_array_if #(.NWAYS(NWAYS), .NSETS(NSETS)) bus ();

  plru_set_array #(.NWAYS(NWAYS), .NSETS(NSETS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Model: last-touch stamp per way; a node points at the half holding the newest stamp.
  int unsigned ts [NSETS][NWAYS];
  int unsigned stamp = 0;
  int          left  = 0;
  bit          mdl_valid = 1'b0;
  int          mdl_way   = 0;

  function automatic void mdl_clear();
    for (int s = 0; s < NSETS; s++)
      for (int w = 0; w < NWAYS; w++) ts[s][w] = 0;
  endfunction

  function automatic void mdl_touch(input int s, input int w);
    stamp++;
    ts[s][w] = stamp;
  endfunction

  function automatic int mdl_victim(input int s, input logic [NWAYS-1:0] mask);
    int lo, size, half, bi;
    int unsigned best;
    for (int i = 0; i < NWAYS; i++)
      if (mask[i]) return i;
    lo   = 0;
    size = NWAYS;
    while (size > 1) begin
      half = size / 2;
      best = 0;
      bi   = -1;
      for (int i = lo; i < lo + size; i++)
        if (ts[s][i] > best) begin
          best = ts[s][i];
          bi   = i;
        end
      if (bi < lo + half) lo = lo + half;
      size = half;
    end
    return lo;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      left      = NSETS;
      mdl_valid = 1'b0;
      mdl_way   = 0;
      mdl_clear();
    end else if (left > 0) begin
      left--;
      mdl_valid = 1'b0;
    end else begin
      if (bus.touch_valid && !bus.flush) mdl_touch(int'(bus.touch_set), int'(bus.touch_way));
      mdl_valid = bus.vreq_valid;
      if (bus.vreq_valid) begin
        mdl_way = mdl_victim(int'(bus.vreq_set), bus.vreq_inv_mask);
`ifdef PLRU_VICTIM_TOUCH_EN
        mdl_touch(int'(bus.vreq_set), mdl_way);
`endif
      end
      if (bus.flush) begin
        mdl_clear();
        left = NSETS;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_busy", 32'(bus.busy), 32'(left > 0));
      check("mon_ready", 32'(bus.vreq_ready), 32'(left == 0));
      check("mon_vrsp_valid", 32'(bus.vrsp_valid), 32'(mdl_valid));
      if (mdl_valid) check("mon_vrsp_way", 32'(bus.vrsp_way), 32'(mdl_way));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic touch(input int s, input int w);
    bus.touch_valid = 1'b1;
    bus.touch_set   = 4'(s);
    bus.touch_way   = 3'(w);
    step();
    bus.touch_valid = 1'b0;
  endtask

  task automatic request(input int s, input logic [NWAYS-1:0] mask, input int exp, input string name);
    bus.vreq_valid    = 1'b1;
    bus.vreq_set      = 4'(s);
    bus.vreq_inv_mask = mask;
    step();
    bus.vreq_valid    = 1'b0;
    bus.vreq_inv_mask = '0;
    check({name, "_valid"}, 32'(bus.vrsp_valid), 32'd1);
    check({name, "_way"}, 32'(bus.vrsp_way), 32'(exp));
    check({name, "_model"}, 32'(mdl_way), 32'(exp));
  endtask

  task automatic wait_idle(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      step();
    end
    check(name, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset             = 1'b1;
    bus.flush         = 1'b0;
    bus.touch_valid   = 1'b0;
    bus.touch_set     = '0;
    bus.touch_way     = '0;
    bus.vreq_valid    = 1'b0;
    bus.vreq_set      = '0;
    bus.vreq_inv_mask = '0;
    step();
    step();
    reset  = 1'b0;
    mon_en = 1'b1;

    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_ready", 32'(bus.vreq_ready), 32'd0);
    check("rst_vrsp_valid", 32'(bus.vrsp_valid), 32'd0);
    check("rst_vrsp_way", 32'(bus.vrsp_way), 32'd0);
    wait_idle("reset_sweep_len", 16);

    request(3, 8'h00, 7, "cleared_set3");
    touch(3, 7);
    request(3, 8'h00, 3, "after_touch7");
    touch(3, 3);
    request(3, 8'h00, 5, "after_touch3");

    // Same-cycle touch and request to one set: victim sees the touch.
    bus.touch_valid = 1'b1;
    bus.touch_set   = 4'd5;
    bus.touch_way   = 3'd7;
    request(5, 8'h00, 3, "forwarded_set5");
    bus.touch_valid = 1'b0;

    request(2, 8'b0010_0100, 2, "inv_mask_set2");
    request(3, 8'b1000_0000, 7, "inv_mask_msb");

    for (int w = 0; w < NWAYS; w++) touch(6, w);
    request(6, 8'h00, 0, "lru_after_sweep_touch");

    touch(0, 5);
    touch(9, 2);
    bus.flush       = 1'b1;
    bus.touch_valid = 1'b1;
    bus.touch_set   = 4'd0;
    bus.touch_way   = 3'd0;
    step();
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd1);
    bus.touch_set = 4'd9;
    bus.touch_way = 3'd7;
    step();
    bus.touch_valid = 1'b0;
    bus.flush       = 1'b1;
    bus.vreq_valid  = 1'b1;
    bus.vreq_set    = 4'd9;
    step();
    bus.flush      = 1'b0;
    bus.vreq_valid = 1'b0;
    check("sweep_no_rsp", 32'(bus.vrsp_valid), 32'd0);
    // 16 busy cycles minus the two already stepped through.
    wait_idle("flush_sweep_len", 14);
    request(0, 8'h00, 7, "flushed_set0");
    request(9, 8'h00, 7, "flushed_set9");

    bus.vreq_valid    = 1'b1;
    bus.vreq_set      = 4'd1;
    bus.vreq_inv_mask = '0;
    step();
    check("b2b_first_valid", 32'(bus.vrsp_valid), 32'd1);
    check("b2b_first_way", 32'(bus.vrsp_way), 32'd7);
    step();
    bus.vreq_valid = 1'b0;
    check("b2b_second_valid", 32'(bus.vrsp_valid), 32'd1);
`ifdef PLRU_VICTIM_TOUCH_EN
    check("b2b_second_way", 32'(bus.vrsp_way), 32'd3);
`else
    check("b2b_second_way", 32'(bus.vrsp_way), 32'd7);
`endif
    step();
    check("idle_no_rsp", 32'(bus.vrsp_valid), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plru_set_array.md
Name: plru_set_array

Overview:
- Parametrised tree-PLRU replacement state for a set-associative TLB or cache, covering NSETS sets × NWAYS ways.
- Holds per-set tree bits in a RAM-style array, updates them on touches, and returns a registered victim way on request.
- Victim selection prefers invalid ways.
- A reset or flush sweeps the array clear over NSETS cycles.
- Sits beside the TLB/cache tag array; the refill logic asks it for the way to replace.

Parameters:
- NWAYS, 8, associativity; power of 2, ≥2.
- NSETS, 16, number of sets; power of 2, ≥1.
- WAY_W, clog2(NWAYS), derived; do not override.
- SET_W, max(1, clog2(NSETS)), derived; do not override.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  pulse; starts a clear sweep.
- busy  out  1  high while a sweep is in progress.
- touch_valid  in  1  record an access.
- touch_set  in  SET_W  set index of the access.
- touch_way  in  WAY_W  way index of the access.
- vreq_valid  in  1  victim request.
- vreq_ready  out  1  equals !busy.
- vreq_set  in  SET_W  set index for the victim request.
- vreq_inv_mask  in  NWAYS  1 = way invalid in that set.
- vrsp_valid  out  1  victim response strobe.
- vrsp_way  out  WAY_W  chosen victim way.

Behaviour:
- Tree encoding:
  - Per set, NWAYS-1 bits hold heap nodes 1..NWAYS-1; node n has children 2n and 2n+1; bit 0 is unused.
  - Node bit = direction of the last touch through that node (1 = upper half).
- Touch: along the path to touch_way, each node bit is set to the corresponding touch_way bit, MSB first at the root. Off-path bits are unchanged. The write commits at the next clk edge.
- Victim:
  - If vreq_inv_mask != 0, victim = lowest-index set bit.
  - Otherwise, from the root, follow the opposite of each node bit; the leaf reached is the victim.
- Handshake:
  - A request is accepted when vreq_valid && vreq_ready.
  - vrsp_valid pulses exactly 1 cycle after acceptance, with vrsp_way; fixed latency 1.
  - Back-to-back requests are accepted every cycle.
- Same-cycle touch and accepted request to the same set: the victim is computed from the post-touch state (forwarded).
- Touch in cycle t and request in cycle t+1: the array is already updated; no hazard.
- FSM states IDLE and SWEEP:
  - reset → SWEEP, ptr = 0.
  - flush in IDLE → SWEEP, ptr = 0.
  - In SWEEP, write set[ptr] = 0 and increment ptr each cycle. Leave for IDLE in the cycle ptr = NSETS-1 is written. busy = 1 for exactly NSETS cycles.
  - reset during SWEEP restarts ptr at 0.
  - flush during SWEEP is ignored.
- While busy: touches are dropped and vreq_ready = 0.
- flush asserted together with touch in IDLE: the flush wins and the touch is dropped.
- Reset values: vrsp_valid = 0, vrsp_way = 0, busy = 1 (from the cycle after reset), vreq_ready = 0. The array contents need no reset (the sweep clears them).
- State after a sweep is all zero, so the victim for an invalid-free set is way NWAYS-1.
- NWAYS = 2: a single node bit per set.
- NSETS = 1: set inputs are ignored (SET_W = 1) and the sweep lasts 1 cycle.

Optional Feature:
- Macro PLRU_VICTIM_TOUCH_EN.
- When defined: an accepted victim request also touches the chosen way in its set, committing at the same edge vrsp_valid rises. If a real touch to the same set occurs in the same cycle, the real touch is applied first and the victim touch second, so the victim becomes MRU.
- When undefined: victim requests never modify state.

Decomposition:
- Package plru_pkg holds:
  - function plru_update(state, way)
  - function plru_victim(state)
  - function lowest_set(mask)
  - sweep FSM state enum {IDLE, SWEEP}
- One combinational sub-module, plru_tree, wraps update/victim for one tree. It is used twice: for the touch path and for the forwarded victim path.

Test Plan (NWAYS=8, NSETS=16):
- Reset, then wait: busy high for exactly 16 cycles, vreq_ready low throughout. Then request set 3 with mask 0 → vrsp_way = 7 one cycle later.
- Touch set 3 way 7, next cycle request set 3 → victim 3. Then touch way 3, request → victim 5.
- Same cycle: touch set 5 way 7 and request set 5, mask 0 → vrsp_way = 3 (forwarded).
- Request set 2 with mask 8'b0010_0100 → vrsp_way = 2 regardless of tree state.
- Touch sets 0 and 9, flush, touch during sweep (dropped). After busy falls, both sets give victim 7.
- With PLRU_VICTIM_TOUCH_EN: after sweep, two consecutive requests to set 1 with mask 0 → victims 7 then 3. Without the macro → 7 then 7.
